hsv_sweep_sequencer: RTL and testbench
======================================

// Module: hsv_sweep_sequencer
// PURPOSE
//  Sequencer for the RGB PWM datapath: walks hue round the colour wheel at a fixed rate.
//  Converts hue to an R/G/B duty triplet (S=V=max).
//  Delivers the triplet to the PWM core over a valid/ready handshake.
//  Core asserts out_ready at its frame boundary, so duties never change mid-frame.
// PARAMETERS
//  PWM_BITS     8      duty width; DMAX = 2^PWM_BITS-1; hue range 0..6*2^PWM_BITS-1
//  STEP_CYCLES  65104  clk cycles per hue step (>=2); default = 1 s sweep at 100 MHz
// PORTS
//  clk        in   1         system clock, all logic on posedge
//  rst_n      in   1         asynchronous, active-low reset
//  run        in   1         level; 1 = sweep advances, 0 = pause
//  restart    in   1         1-cycle pulse; hue and divider to 0
//  out_ready  in   1         PWM core accepts triplet this cycle
//  out_valid  out  1         triplet on duty_* valid
//  duty_r     out  PWM_BITS  red duty
//  duty_g     out  PWM_BITS  green duty
//  duty_b     out  PWM_BITS  blue duty
//  sector     out  3         hue sector (0..5) of the presented triplet
//  wrap       out  1         1-cycle pulse when hue wraps max->0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, hue=0, div=0, pending=0, out_valid=0, duty_*=0, sector=0, wrap=0.
//  FSM: IDLE -run-> RUN (pending<=1); RUN -!run-> PAUSE; PAUSE -run-> RUN.
//   - RUN: div counts 0..STEP_CYCLES-1; at terminal count hue<=hue+1, div<=0, pending<=1.
//   - PAUSE: div and hue frozen; resume continues from the frozen div value.
//  Hue wrap: hue=6*2^PWM_BITS-1 steps to 0; wrap=1 for exactly that cycle.
//  restart (any state): hue<=0, div<=0, pending<=1, state unchanged; wins over a same-cycle step.
//  No wrap pulse on restart.
//  Mapping: s=hue>>PWM_BITS, f=hue[PWM_BITS-1:0], nf=DMAX-f:
//   - s0: (DMAX, f, 0)
//   - s1: (nf, DMAX, 0)
//   - s2: (0, DMAX, f)
//   - s3: (0, nf, DMAX)
//   - s4: (f, 0, DMAX)
//   - s5: (DMAX, 0, nf)
//  Output slot free when !out_valid, or out_valid&&out_ready.
//  If pending && slot free: load duty_*/sector from current hue, out_valid<=1, pending<=0.
//  Load latency: 1 cycle after the hue update.
//  Accept with no pending: out_valid<=0 next cycle.
//  Backpressure: while out_valid && !out_ready, duty_*/sector held stable.
//   - Hue keeps advancing.
//   - Intermediate steps are coalesced: only the latest hue is loaded after accept.
//  Accept and new pending in the same cycle: next triplet loads with no bubble.
//  All outputs registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  HSV_GAMMA_EN defined: each duty passes through d' = (d*(d+1))>>PWM_BITS before the output register.
//   - Maps 0->0 and DMAX->DMAX; perceptual dimming.
//   - Same latency as without it.
//  HSV_GAMMA_EN undefined: duties are the linear mapping above.
// TESTING (PWM_BITS=4, STEP_CYCLES=4, DMAX=15, hue 0..95)
//  1. rst_n=0 -> all outputs 0; release with run=0 for 50 cycles -> out_valid stays 0, hue 0.
//  2. run=1, out_ready=1:
//     - first triplet (15,0,0) s0
//     - hue 16 -> (15,15,0) s1
//     - hue 40 -> (0,15,8) s2
//     - hue 88 -> (15,0,7) s5
//  3. Full sweep, 96 steps (384 cycles): wrap high for one cycle; next triplet (15,0,0) s0.
//  4. out_ready=0 for 20 cycles: triplet held, out_valid=1; out_ready=1 -> next-cycle triplet = current hue (5 steps later).
//  5. run=0 at hue 20 for 100 cycles -> hue frozen.
//     - restart coincident with a step tick -> hue 0, triplet (15,0,0).
//     - rst_n pulsed low mid-cycle -> outputs 0 before the next clk edge.
//  6. HSV_GAMMA_EN, hue 8 -> (15,4,0); hue 15 -> (15,15,0).

Source files
------------

// File: rtl/hsv_sweep_sequencer.sv
// hsv_sweep_sequencer
//   Walks hue around the colour wheel at a fixed rate and presents the
//   matching full-saturation, full-value R/G/B duty triplet to the PWM core.
//
//   Handshake: out_valid/out_ready. A triplet transfers on any cycle where
//   out_valid && out_ready are both high at the clock edge. While out_valid is
//   high and out_ready is low, duty_*/sector are held unchanged. out_valid is
//   only dropped after a transfer with nothing new to send.
//
//   Optional build macro HSV_GAMMA_EN: when defined, each duty is shaped by
//   d' = (d*(d+1)) >> PWM_BITS ahead of the output register. Latency is the
//   same in both builds.
module hsv_sweep_sequencer #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 65104
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                restart,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [PWM_BITS-1:0] duty_r,
  output logic [PWM_BITS-1:0] duty_g,
  output logic [PWM_BITS-1:0] duty_b,
  output logic [2:0]          sector,
  output logic                wrap
);

  // Hue spans six sectors of 2^PWM_BITS steps each, so three extra bits.
  localparam int                 HUE_W    = PWM_BITS + 3;
  localparam logic [HUE_W-1:0]   HUE_MAX  = HUE_W'(6 * (2 ** PWM_BITS) - 1);
  localparam int                 DIV_W    = $clog2(STEP_CYCLES);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DMAX    = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t              state;
  logic [HUE_W-1:0]    hue;
  logic [DIV_W-1:0]    div;
  logic                pending;

  logic                counting;
  logic                step_tick;
  logic                start;
  logic                pending_set;
  logic                slot_free;
  logic                load;

  logic [2:0]          hue_sec;
  logic [PWM_BITS-1:0] hue_f;
  logic [PWM_BITS-1:0] hue_nf;
  logic [PWM_BITS-1:0] lin_r;
  logic [PWM_BITS-1:0] lin_g;
  logic [PWM_BITS-1:0] lin_b;
  logic [PWM_BITS-1:0] nxt_r;
  logic [PWM_BITS-1:0] nxt_g;
  logic [PWM_BITS-1:0] nxt_b;

`ifdef HSV_GAMMA_EN
  // Squaring-style curve; endpoints 0 and DMAX map onto themselves.
  function automatic logic [PWM_BITS-1:0] gamma_fn(input logic [PWM_BITS-1:0] d);
    logic [2*PWM_BITS-1:0] p;
    p = (2*PWM_BITS)'(d) * ((2*PWM_BITS)'(d) + (2*PWM_BITS)'(1));
    return p[2*PWM_BITS-1:PWM_BITS];
  endfunction
`endif

  // Step/handshake qualifiers shared by the control and output registers.
  always_comb begin
    counting    = (state == ST_RUN) && run;
    step_tick   = counting && (div == DIV_LAST);
    start       = (state == ST_IDLE) && run;
    pending_set = start || step_tick || restart;
    slot_free   = !out_valid || out_ready;
    load        = pending && slot_free;
  end

  // Hue to linear duty triplet: rising/falling ramp per 60-degree sector.
  always_comb begin
    hue_sec = hue[HUE_W-1:PWM_BITS];
    hue_f   = hue[PWM_BITS-1:0];
    hue_nf  = DMAX - hue_f;
    lin_r   = '0;
    lin_g   = '0;
    lin_b   = '0;
    case (hue_sec)
      3'd0:    begin lin_r = DMAX;   lin_g = hue_f;  lin_b = '0;     end
      3'd1:    begin lin_r = hue_nf; lin_g = DMAX;   lin_b = '0;     end
      3'd2:    begin lin_r = '0;     lin_g = DMAX;   lin_b = hue_f;  end
      3'd3:    begin lin_r = '0;     lin_g = hue_nf; lin_b = DMAX;   end
      3'd4:    begin lin_r = hue_f;  lin_g = '0;     lin_b = DMAX;   end
      3'd5:    begin lin_r = DMAX;   lin_g = '0;     lin_b = hue_nf; end
      default: begin lin_r = '0;     lin_g = '0;     lin_b = '0;     end
    endcase
  end

  // Optional perceptual shaping ahead of the output register.
  always_comb begin
`ifdef HSV_GAMMA_EN
    nxt_r = gamma_fn(lin_r);
    nxt_g = gamma_fn(lin_g);
    nxt_b = gamma_fn(lin_b);
`else
    nxt_r = lin_r;
    nxt_g = lin_g;
    nxt_b = lin_b;
`endif
  end

  // Control FSM: run/pause state, step divider, hue, pending flag, wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      hue     <= '0;
      div     <= '0;
      pending <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;

      case (state)
        ST_IDLE:  if (run)  state <= ST_RUN;
        ST_RUN:   if (!run) state <= ST_PAUSE;
        ST_PAUSE: if (run)  state <= ST_RUN;
        default:            state <= ST_IDLE;
      endcase

      // A fresh hue always wins over clearing; a same-cycle load took the old one.
      if (pending_set) begin
        pending <= 1'b1;
      end else if (load) begin
        pending <= 1'b0;
      end

      // restart overrides a coincident step and never raises wrap.
      if (restart) begin
        hue <= '0;
        div <= '0;
      end else if (counting) begin
        if (div == DIV_LAST) begin
          div <= '0;
          if (hue == HUE_MAX) begin
            hue  <= '0;
            wrap <= 1'b1;
          end else begin
            hue <= hue + 1'b1;
          end
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

  // Output slot: load the latest hue when free, otherwise hold or retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      duty_r    <= '0;
      duty_g    <= '0;
      duty_b    <= '0;
      sector    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      duty_r    <= nxt_r;
      duty_g    <= nxt_g;
      duty_b    <= nxt_b;
      sector    <= hue_sec;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hsv_sweep_sequencer.sv
// Directed bench for hsv_sweep_sequencer with PWM_BITS=4, STEP_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// "cyc" counts rising edges since run was first raised: hue k is stepped in
// at edge 1+4k and presented at edge 2+4k while out_ready is held high.
module tb_hsv_sweep_sequencer;

  localparam int PB = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic          restart;
  logic          out_ready;
  logic          out_valid;
  logic [PB-1:0] duty_r;
  logic [PB-1:0] duty_g;
  logic [PB-1:0] duty_b;
  logic [2:0]    sector;
  logic          wrap;

  int total    = 0;
  int bad      = 0;
  int cyc      = 0;
  int wrap_cnt = 0;

  hsv_sweep_sequencer #(.PWM_BITS(PB), .STEP_CYCLES(SC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .restart   (restart),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .duty_r    (duty_r),
    .duty_g    (duty_g),
    .duty_b    (duty_b),
    .sector    (sector),
    .wrap      (wrap)
  );

  // Clock.
  always #5 clk = ~clk;

  // Expected duty after optional shaping.
  function automatic logic [PB-1:0] gam(input logic [PB-1:0] d);
`ifdef HSV_GAMMA_EN
    logic [2*PB-1:0] p;
    p = {4'b0000, d} * ({4'b0000, d} + 8'd1);
    return p[2*PB-1:PB];
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (wrap === 1'b1) wrap_cnt++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_trip(input string tag, input logic [PB-1:0] r, input logic [PB-1:0] g,
                          input logic [PB-1:0] b, input logic [2:0] s);
    chk({tag, ".valid"},  32'(out_valid), 32'd1);
    chk({tag, ".r"},      32'(duty_r),    32'(gam(r)));
    chk({tag, ".g"},      32'(duty_g),    32'(gam(g)));
    chk({tag, ".b"},      32'(duty_b),    32'(gam(b)));
    chk({tag, ".sector"}, 32'(sector),    32'(s));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"},  32'(out_valid), 32'd0);
    chk({tag, ".r"},      32'(duty_r),    32'd0);
    chk({tag, ".g"},      32'(duty_g),    32'd0);
    chk({tag, ".b"},      32'(duty_b),    32'd0);
    chk({tag, ".sector"}, 32'(sector),    32'd0);
    chk({tag, ".wrap"},   32'(wrap),      32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    run       = 1'b0;
    restart   = 1'b0;
    out_ready = 1'b0;

    // Reset, then 50 idle cycles with run low.
    tick();
    chk_zero("reset");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    chk("idle.valid", 32'(out_valid), 32'd0);
    chk("idle.wrap_cnt", 32'(wrap_cnt), 32'd0);

    // Sweep with the core always ready.
    run       = 1'b1;
    out_ready = 1'b1;
    cyc       = 0;
    run_to(2);   chk_trip("hue0", 4'd15, 4'd0,  4'd0, 3'd0);
    run_to(3);   chk("hue0.retire", 32'(out_valid), 32'd0);
    run_to(34);  chk_trip("hue8",  4'd15, 4'd8,  4'd0, 3'd0);
    run_to(62);  chk_trip("hue15", 4'd15, 4'd15, 4'd0, 3'd0);
    run_to(66);  chk_trip("hue16", 4'd15, 4'd15, 4'd0, 3'd1);
    run_to(162); chk_trip("hue40", 4'd0,  4'd15, 4'd8, 3'd2);
    run_to(354); chk_trip("hue88", 4'd15, 4'd0,  4'd7, 3'd5);
    run_to(382); chk_trip("hue95", 4'd15, 4'd0,  4'd0, 3'd5);

    // Wrap 95 -> 0.
    run_to(384); chk("wrap.before", 32'(wrap), 32'd0);
    run_to(385); chk("wrap.pulse",  32'(wrap), 32'd1);
    run_to(386); chk("wrap.after",  32'(wrap), 32'd0);
    chk_trip("wrap.hue0", 4'd15, 4'd0, 4'd0, 3'd0);
    chk("wrap.count", 32'(wrap_cnt), 32'd1);

    // Backpressure: hold hue1 for 20 cycles, then coalesced jump to hue6.
    run_to(390); chk_trip("bp.hue1", 4'd15, 4'd1, 4'd0, 3'd0);
    out_ready = 1'b0;
    run_to(410); chk_trip("bp.held", 4'd15, 4'd1, 4'd0, 3'd0);
    out_ready = 1'b1;
    run_to(411); chk_trip("bp.hue6", 4'd15, 4'd6, 4'd0, 3'd0);
    run_to(412); chk("bp.retire", 32'(out_valid), 32'd0);

    // Pause at hue 20 for 100 cycles.
    run_to(466); chk_trip("hue20", 4'd11, 4'd15, 4'd0, 3'd1);
    run = 1'b0;
    run_to(566); chk("pause.valid", 32'(out_valid), 32'd0);
    run = 1'b1;
    run_to(570); chk("resume.pre", 32'(out_valid), 32'd0);
    run_to(571); chk_trip("resume.hue21", 4'd10, 4'd15, 4'd0, 3'd1);

    // restart on the same edge as the hue 22 step.
    run_to(573);
    restart = 1'b1;
    run_to(574);
    restart = 1'b0;
    chk("restart.wrap",  32'(wrap),      32'd0);
    chk("restart.valid", 32'(out_valid), 32'd0);
    run_to(575); chk_trip("restart.hue0", 4'd15, 4'd0, 4'd0, 3'd0);
    chk("restart.wrap_cnt", 32'(wrap_cnt), 32'd1);
    run_to(579); chk_trip("restart.hue1", 4'd15, 4'd1, 4'd0, 3'd0);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst.valid", 32'(out_valid), 32'd0);
    tick();
    chk_trip("post_rst.hue0", 4'd15, 4'd0, 4'd0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
